// File: rtl/circus_gfx_pkg.sv
// Shared graphics types for the circus display pipeline, plus the sprite texel pattern
// that the bitmap ROM is filled from.
package circus_gfx_pkg;

  typedef logic [7:0]  rgb_t;
  typedef logic [10:0] coord_t;

  localparam rgb_t TRANSPARENT_COLOR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HIDE = 2'd2
  } blink_state_t;

  // Texel art: every column with x%8==5 is see-through, the rest encode frame/y/x in the colour.
  function automatic rgb_t texel_pattern(input logic [7:0] f, input logic [7:0] y,
                                         input logic [7:0] x);
    rgb_t t;
    if (x[2:0] == 3'd5) begin
      t = TRANSPARENT_COLOR;
    end else begin
      t = 8'hE0 ^ {f[1:0], y[2:0], x[2:0]};
    end
    return t;
  endfunction

endpackage

// File: rtl/sprite_bitmap_rom.sv
// Sprite bitmap lookup table addressed by {frame, y, x}; the data output is registered.
module sprite_bitmap_rom
  import circus_gfx_pkg::*;
#(
  parameter int FW = 2,
  parameter int YW = 5,
  parameter int XW = 5
) (
  input  logic          clk,
  input  logic [FW-1:0] frame,
  input  logic [YW-1:0] y,
  input  logic [XW-1:0] x,
  output rgb_t          data
);

  // Registered texel read.
  always_ff @(posedge clk) begin
    data <= texel_pattern(8'(frame), 8'(y), 8'(x));
  end

endmodule

// File: rtl/sprite_frame_drawer.sv
// Animated, flashable sprite feeding one request/RGB pair of the priority objects mux.
// Optional build macro SPRITE_MIRROR_EN enables horizontal mirroring through flipH.
module sprite_frame_drawer
  import circus_gfx_pkg::*;
#(
  parameter int OBJ_WIDTH    = 32,
  parameter int OBJ_HEIGHT   = 32,
  parameter int FRAMES       = 4,
  parameter int FRAME_HOLD   = 8,
  parameter int FLASH_FRAMES = 32,
  parameter int BLINK_PERIOD = 4
) (
  input  logic   clk,
  input  logic   resetN,
  input  coord_t pixelX,
  input  coord_t pixelY,
  input  coord_t topLeftX,
  input  coord_t topLeftY,
  input  logic   startOfFrame,
  input  logic   animEnable,
  input  logic   hitPulse,
  input  logic   flipH,
  output logic   drawingRequest,
  output rgb_t   RGBout,
  output logic   flashing
);

  localparam int XW  = $clog2(OBJ_WIDTH);
  localparam int YW  = $clog2(OBJ_HEIGHT);
  localparam int FW  = $clog2(FRAMES);
  localparam int HW  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PCW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  localparam logic [HW-1:0]  HOLD_LAST  = HW'(FRAME_HOLD - 1);
  localparam logic [FW-1:0]  FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_FRAMES - 1);
  localparam logic [PCW-1:0] PHASE_LAST = PCW'(BLINK_PERIOD - 1);

  logic          inside_s, inside_r, inside_d_r, hide_d_r;
  logic [11:0]   end_x_s, end_y_s;
  logic [XW-1:0] off_x_s, off_x_r, rom_x_s;
  logic [YW-1:0] off_y_s, off_y_r;
  logic [FW-1:0] frame_idx_r;
  logic [HW-1:0] hold_cnt_r;
  rgb_t          rom_data_s;

  blink_state_t   state_r, state_n;
  logic [FCW-1:0] flash_cnt_r, flash_cnt_n;
  logic [PCW-1:0] phase_cnt_r, phase_cnt_n;

  // S1 box test; the far edge is formed at 12 bits so a sprite near 2047 clips instead of wrapping.
  always_comb begin
    end_x_s  = {1'b0, topLeftX} + 12'(OBJ_WIDTH);
    end_y_s  = {1'b0, topLeftY} + 12'(OBJ_HEIGHT);
    inside_s = ({1'b0, pixelX} >= {1'b0, topLeftX}) && ({1'b0, pixelX} < end_x_s) &&
               ({1'b0, pixelY} >= {1'b0, topLeftY}) && ({1'b0, pixelY} < end_y_s);
    off_x_s  = XW'(pixelX - topLeftX);
    off_y_s  = YW'(pixelY - topLeftY);
  end

  // S1 pipeline register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      inside_r <= 1'b0;
      off_x_r  <= '0;
      off_y_r  <= '0;
    end else begin
      inside_r <= inside_s;
      off_x_r  <= off_x_s;
      off_y_r  <= off_y_s;
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic flip_r;

  // Mirror select travels with its pixel through S1.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      flip_r <= 1'b0;
    end else begin
      flip_r <= flipH;
    end
  end

  assign rom_x_s = flip_r ? (XW'(OBJ_WIDTH - 1) - off_x_r) : off_x_r;
`else
  logic unused_flip_s;
  assign unused_flip_s = flipH;
  assign rom_x_s       = off_x_r;
`endif

  sprite_bitmap_rom #(.FW(FW), .YW(YW), .XW(XW)) u_rom (
    .clk   (clk),
    .frame (frame_idx_r),
    .y     (off_y_r),
    .x     (rom_x_s),
    .data  (rom_data_s)
  );

  // S2 side-band: box flag and blink visibility aligned with the ROM read.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      inside_d_r <= 1'b0;
      hide_d_r   <= 1'b0;
    end else begin
      inside_d_r <= inside_r;
      hide_d_r   <= (state_r == HIDE);
    end
  end

  // S2 output gating.
  always_comb begin
    drawingRequest = inside_d_r && (rom_data_s != TRANSPARENT_COLOR) && !hide_d_r;
    if (drawingRequest) begin
      RGBout = rom_data_s;
    end else begin
      RGBout = 8'h00;
    end
  end

  // Animation: hold each frame for FRAME_HOLD enabled frame pulses.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      hold_cnt_r  <= '0;
      frame_idx_r <= '0;
    end else if (startOfFrame && animEnable) begin
      if (hold_cnt_r == HOLD_LAST) begin
        hold_cnt_r  <= '0;
        frame_idx_r <= (frame_idx_r == FRAME_LAST) ? '0 : frame_idx_r + FW'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r + HW'(1);
      end
    end
  end

  // Blink FSM state register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r     <= IDLE;
      flash_cnt_r <= '0;
      phase_cnt_r <= '0;
    end else begin
      state_r     <= state_n;
      flash_cnt_r <= flash_cnt_n;
      phase_cnt_r <= phase_cnt_n;
    end
  end

  // Blink FSM next state; a hit always restarts in HIDE, even on a frame pulse.
  always_comb begin
    state_n     = state_r;
    flash_cnt_n = flash_cnt_r;
    phase_cnt_n = phase_cnt_r;
    if (hitPulse) begin
      state_n     = HIDE;
      flash_cnt_n = '0;
      phase_cnt_n = '0;
    end else if (startOfFrame) begin
      case (state_r)
        SHOW, HIDE: begin
          if (flash_cnt_r == FLASH_LAST) begin
            state_n     = IDLE;
            flash_cnt_n = '0;
            phase_cnt_n = '0;
          end else begin
            flash_cnt_n = flash_cnt_r + FCW'(1);
            if (phase_cnt_r == PHASE_LAST) begin
              phase_cnt_n = '0;
              state_n     = (state_r == SHOW) ? HIDE : SHOW;
            end else begin
              phase_cnt_n = phase_cnt_r + PCW'(1);
            end
          end
        end
        default: begin
          state_n     = IDLE;
          flash_cnt_n = '0;
          phase_cnt_n = '0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  assign flashing = (state_r != IDLE);

endmodule

// File: tb/tb_sprite_frame_drawer.sv
// Self-checking bench for sprite_frame_drawer: directed steps plus random traffic against a
// frame-counting reference model.
module tb_sprite_frame_drawer;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        startOfFrame, animEnable, hitPulse, flipH;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        flashing;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending S1 pixel, frame-pulse counters, expected outputs.
  bit       m_in, m_flip, m_active;
  int       m_ox, m_oy, m_anim, m_n;
  bit       e_dr;
  bit [7:0] e_rgb;

  always #5 clk = ~clk;

  sprite_frame_drawer dut (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .startOfFrame   (startOfFrame),
    .animEnable     (animEnable),
    .hitPulse       (hitPulse),
    .flipH          (flipH),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout),
    .flashing       (flashing)
  );

  function automatic bit [7:0] ref_texel(int f, int y, int x);
    int v;
    if (x % 8 == 5) return 8'hFF;
    v = 224 ^ (f * 64 + (y % 8) * 8 + (x % 8));
    return 8'(v);
  endfunction

  // One rising edge of the reference: outputs from the old state, then state update.
  task automatic model_edge();
    int f, xa;
    bit hide;
    bit [7:0] t;
    if (!resetN) begin
      m_in = 0; m_flip = 0; e_dr = 0; e_rgb = 8'h00;
      m_anim = 0; m_active = 0; m_n = 0;
      return;
    end
    f    = (m_anim / 8) % 4;
    hide = m_active && ((m_n / 4) % 2 == 0);
    if (m_in) begin
      xa = m_ox;
`ifdef SPRITE_MIRROR_EN
      if (m_flip) xa = 31 - m_ox;
`endif
      t     = ref_texel(f, m_oy, xa);
      e_dr  = (t != 8'hFF) && !hide;
      e_rgb = e_dr ? t : 8'h00;
    end else begin
      e_dr  = 0;
      e_rgb = 8'h00;
    end
    m_in = (int'(pixelX) >= int'(topLeftX)) && (int'(pixelX) < int'(topLeftX) + 32) &&
           (int'(pixelY) >= int'(topLeftY)) && (int'(pixelY) < int'(topLeftY) + 32);
    m_ox   = (int'(pixelX) - int'(topLeftX)) & 31;
    m_oy   = (int'(pixelY) - int'(topLeftY)) & 31;
    m_flip = flipH;
    if (startOfFrame && animEnable) m_anim++;
    if (hitPulse) begin
      m_active = 1;
      m_n      = 0;
    end else if (startOfFrame && m_active) begin
      m_n++;
      if (m_n >= 32) m_active = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one pixel clock, advance the model, then compare all outputs.
  task automatic tick(input int px, input int py, input bit sof, input bit hit);
    pixelX       = 11'(px);
    pixelY       = 11'(py);
    startOfFrame = sof;
    hitPulse     = hit;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("drawingRequest", 32'(drawingRequest), 32'(e_dr));
    chk("RGBout", 32'(RGBout), 32'(e_rgb));
    chk("flashing", 32'(flashing), 32'(m_active));
    startOfFrame = 1'b0;
    hitPulse     = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; topLeftX = 11'd100; topLeftY = 11'd50;
    pixelX = 11'd0; pixelY = 11'd0;
    startOfFrame = 1'b0; animEnable = 1'b0; hitPulse = 1'b0; flipH = 1'b0;
    @(negedge clk);
    repeat (3) tick(0, 0, 0, 0);
    chk("reset_dr", 32'(drawingRequest), 32'd0);
    chk("reset_flashing", 32'(flashing), 32'd0);
    resetN = 1'b1;

    // Top-left pixel, two-clock latency.
    tick(100, 50, 0, 0);
    tick(0, 0, 0, 0);
    chk("topleft_dr", 32'(drawingRequest), 32'd1);
    chk("topleft_rgb", 32'(RGBout), 32'h0000_00E0);

    // Right edge: x=131 inside, x=132 outside.
    tick(131, 50, 0, 0);
    tick(132, 50, 0, 0);
    chk("right_edge_in", 32'(RGBout), 32'h0000_00E7);
    tick(0, 0, 0, 0);
    chk("right_edge_out", 32'(drawingRequest), 32'd0);

    // Transparent texel inside the box.
    tick(105, 50, 0, 0);
    tick(0, 0, 0, 0);
    chk("transparent_dr", 32'(drawingRequest), 32'd0);
    chk("transparent_rgb", 32'(RGBout), 32'd0);

    // Sprite near the right screen edge is clipped, not wrapped.
    topLeftX = 11'd2030;
    for (int x = 2030; x <= 2047; x++) tick(x, 60, 0, 0);
    tick(0, 60, 0, 0);
    chk("clip_last_in", 32'(drawingRequest), 32'd1);
    for (int x = 1; x <= 13; x++) tick(x, 60, 0, 0);
    chk("clip_wrap_out", 32'(drawingRequest), 32'd0);
    topLeftX = 11'd100;

    // Animation: 16 enabled pulses, 4 frozen, 16 enabled -> back to frame 0.
    for (int p = 0; p < 36; p++) begin
      animEnable = !(p >= 16 && p < 20);
      tick(500, 500, 1, 0);
      tick(100, 50, 0, 0);
      tick(0, 0, 0, 0);
      if (p == 16) chk("anim_frame2", 32'(RGBout), 32'h0000_0060);
      if (p == 19) chk("anim_frozen", 32'(RGBout), 32'h0000_0060);
    end
    chk("anim_wrap", 32'(RGBout), 32'h0000_00E0);
    animEnable = 1'b0;

    // Blink: hit, then restart together with a frame pulse at frame 10.
    tick(0, 0, 0, 1);
    for (int fr = 0; fr < 46; fr++) begin
      tick(500, 500, 1, (fr == 10));
      tick(100, 50, 0, 0);
      tick(0, 0, 0, 0);
      if (fr == 1) chk("blink_hidden", 32'(drawingRequest), 32'd0);
      if (fr == 5) chk("blink_shown", 32'(drawingRequest), 32'd1);
    end
    chk("blink_done", 32'(flashing), 32'd0);

    // Reset mid-blink and mid-animation.
    animEnable = 1'b1;
    tick(0, 0, 0, 1);
    for (int p = 0; p < 9; p++) tick(500, 500, 1, 0);
    resetN = 1'b0;
    repeat (3) tick(100, 50, 1, 0);
    resetN = 1'b1;
    animEnable = 1'b0;
    chk("midblink_reset_flash", 32'(flashing), 32'd0);
    tick(100, 50, 0, 0);
    tick(0, 0, 0, 0);
    chk("midblink_reset_frame0", 32'(RGBout), 32'h0000_00E0);

    // Mirror select at offX=0.
    flipH = 1'b1;
    tick(100, 50, 0, 0);
    tick(0, 0, 0, 0);
`ifdef SPRITE_MIRROR_EN
    chk("mirror_offx0", 32'(RGBout), 32'h0000_00E7);
`else
    chk("mirror_ignored", 32'(RGBout), 32'h0000_00E0);
`endif

    // Random traffic around a moving sprite.
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) begin
        topLeftX = 11'($urandom_range(0, 2047));
        topLeftY = 11'($urandom_range(0, 2047));
      end
      if ($urandom_range(0, 31) == 0) animEnable = 1'($urandom_range(0, 1));
      flipH  = 1'($urandom_range(0, 1));
      resetN = ($urandom_range(0, 599) != 0);
      tick(int'(topLeftX) + $urandom_range(0, 40) - 4,
           int'(topLeftY) + $urandom_range(0, 40) - 4,
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
